// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared types, widths and saturating-add helper for the race controller
package race_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RACE  = 2'd2,
    ST_DONE  = 2'd3
  } race_state_e;

  localparam int WIN_W = 3;
  // Wide enough for any POS_W up to 32 plus headroom so sums never wrap.
  localparam int SAT_W = 33;

  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input logic [SAT_W-1:0] lim);
    logic [SAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/race_ctrl_if.sv
// rtl/race_ctrl_if.sv - control/status bundle between the race controller and its driver
interface race_ctrl_if #(
  parameter int N_PLAYERS = 2,
  parameter int POS_W     = 32,
  parameter int SPD_W     = 4,
  parameter int CNT_W     = 5
);
  logic                       tick;
  logic                       start;
  logic [N_PLAYERS-1:0]       key;
  logic [N_PLAYERS*POS_W-1:0] pos;
  logic [N_PLAYERS*SPD_W-1:0] speed;
  logic [1:0]                 state;
  logic [CNT_W-1:0]           count;
  logic [N_PLAYERS-1:0]       false_start;
  logic [N_PLAYERS-1:0]       finished;
  logic [2:0]                 winner;
  logic                       winner_vld;
  logic                       tie;

  modport master (
    output tick, start, key,
    input  pos, speed, state, count, false_start, finished, winner, winner_vld, tie
  );

  modport slave (
    input  tick, start, key,
    output pos, speed, state, count, false_start, finished, winner, winner_vld, tie
  );
endinterface

// File: rtl/race_lane.sv
// rtl/race_lane.sv - one lane: speed/position with accel, drag, saturation and sticky flags
module race_lane
  import race_pkg::*;
#(
  parameter int POS_W     = 32,
  parameter int SPD_W     = 4,
  parameter int TRACK_LEN = 4000,
  parameter int MAX_SPEED = 15,
  parameter int ACCEL     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             key,
  input  logic             disq_en,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic [SPD_W-1:0] speed,
  output logic             finished,
  output logic             false_start,
  output logic             fin_now
);

  logic [POS_W-1:0] pos_q, pos_d;
  logic [SPD_W-1:0] spd_q, spd_d, spd_new;
  logic             fin_q, fin_d, fs_q, fs_d;
  logic             active;
  logic [SAT_W-1:0] spd_acc, pos_sum;

  assign active = !fs_q && !fin_q;

  always_comb begin
    pos_d   = pos_q;
    spd_d   = spd_q;
    fin_d   = fin_q;
    fs_d    = fs_q;
    spd_acc = sat_add(SAT_W'(spd_q), SAT_W'(ACCEL), SAT_W'(MAX_SPEED));
    if (key) begin
      spd_new = SPD_W'(spd_acc);
    end else begin
      spd_new = (spd_q == '0) ? '0 : spd_q - 1'b1;
    end
    pos_sum = sat_add(SAT_W'(pos_q), SAT_W'(spd_new), SAT_W'(TRACK_LEN));
    fin_now = tick_en && active && (pos_sum == SAT_W'(TRACK_LEN));

    if (clr) begin
      pos_d = '0;
      spd_d = '0;
      fin_d = 1'b0;
      fs_d  = 1'b0;
    end else begin
      if (disq_en && key) fs_d = 1'b1;
      if (tick_en && active) begin
        pos_d = POS_W'(pos_sum);
        spd_d = fin_now ? '0 : spd_new;
        fin_d = fin_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_q <= '0;
      spd_q <= '0;
      fin_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      pos_q <= pos_d;
      spd_q <= spd_d;
      fin_q <= fin_d;
      fs_q  <= fs_d;
    end
  end

  assign pos         = pos_q;
  assign speed       = spd_q;
  assign finished    = fin_q;
  assign false_start = fs_q;

endmodule

// File: rtl/race_ctrl.sv
// rtl/race_ctrl.sv - race FSM, countdown and winner arbitration over N lanes
module race_ctrl
  import race_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int POS_W     = 32,
  parameter int TRACK_LEN = 4000,
  parameter int MAX_SPEED = 15,
  parameter int ACCEL     = 1,
  parameter int COUNTDOWN = 30
) (
  input logic        clk,
  input logic        rst,
  race_ctrl_if.slave bus
);

  localparam int SPD_W = $clog2(MAX_SPEED + 1);
  localparam int CNT_W = $clog2(COUNTDOWN + 1);

  race_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIN_W-1:0] winner_q, winner_d, win_idx;
  logic             wvld_q, wvld_d, tie_q, tie_d;
  logic [3:0]       n_fin;

  logic tick_en, disq_en, clr;
  logic [N_PLAYERS-1:0]       fin_now, finished, false_start;
  logic [N_PLAYERS*POS_W-1:0] pos_w;
  logic [N_PLAYERS*SPD_W-1:0] spd_w;

  assign tick_en = bus.tick && (state_q == ST_RACE);
  assign disq_en = (state_q == ST_COUNT);
  assign clr     = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_lane
    race_lane #(
      .POS_W(POS_W), .SPD_W(SPD_W), .TRACK_LEN(TRACK_LEN),
      .MAX_SPEED(MAX_SPEED), .ACCEL(ACCEL)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .tick_en    (tick_en),
      .key        (bus.key[g]),
      .disq_en    (disq_en),
      .clr        (clr),
      .pos        (pos_w[g*POS_W +: POS_W]),
      .speed      (spd_w[g*SPD_W +: SPD_W]),
      .finished   (finished[g]),
      .false_start(false_start[g]),
      .fin_now    (fin_now[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    winner_d = winner_q;
    wvld_d   = wvld_q;
    tie_d    = tie_q;
    win_idx  = '0;
    n_fin    = '0;
    // Descending scan so the lowest-index finisher wins.
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (fin_now[i]) win_idx = WIN_W'(i);
    end
    for (int i = 0; i < N_PLAYERS; i++) begin
      n_fin = n_fin + 4'(fin_now[i]);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d  = ST_COUNT;
          count_d  = CNT_W'(COUNTDOWN);
          winner_d = '0;
          wvld_d   = 1'b0;
          tie_d    = 1'b0;
        end
      end
      ST_COUNT: begin
        if (bus.tick) begin
          if (count_q <= CNT_W'(1)) begin
            count_d = '0;
            state_d = ST_RACE;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
      ST_RACE: begin
        if (!wvld_q && (|fin_now)) begin
          winner_d = win_idx;
          wvld_d   = 1'b1;
          tie_d    = (n_fin > 4'd1);
        end
        if (&(finished | fin_now | false_start)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      winner_q <= '0;
      wvld_q   <= 1'b0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      winner_q <= winner_d;
      wvld_q   <= wvld_d;
      tie_q    <= tie_d;
    end
  end

  assign bus.pos         = pos_w;
  assign bus.speed       = spd_w;
  assign bus.state       = state_q;
  assign bus.count       = count_q;
  assign bus.false_start = false_start;
  assign bus.finished    = finished;
  assign bus.winner      = winner_q;
  assign bus.winner_vld  = wvld_q;
  assign bus.tie         = tie_q;

endmodule

// File: tb/tb_race_ctrl.sv
// tb/tb_race_ctrl.sv - scoreboard bench for race_ctrl with directed race scenarios
module tb_race_ctrl;

  localparam int TL = 400;

  typedef struct {
    string name;
    int st, cnt, p0, p1, s0, s1, fs, fin, win, wv, tie;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  race_ctrl_if #(.N_PLAYERS(2), .POS_W(16), .SPD_W(4), .CNT_W(2)) bus ();

  race_ctrl #(
    .N_PLAYERS(2), .POS_W(16), .TRACK_LEN(TL),
    .MAX_SPEED(15), .ACCEL(1), .COUNTDOWN(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t mk(input string n, input int st, input int cnt,
                              input int p0, input int p1, input int s0, input int s1,
                              input int fs, input int fin, input int win,
                              input int wv, input int tie);
    exp_t e;
    e.name = n; e.st = st; e.cnt = cnt; e.p0 = p0; e.p1 = p1; e.s0 = s0; e.s1 = s1;
    e.fs = fs; e.fin = fin; e.win = win; e.wv = wv; e.tie = tie;
    return e;
  endfunction

  // Closed-form position after i held ticks from standstill (1+2+..+15, then 15 per tick).
  function automatic int acc_pos(input int i);
    return (i <= 15) ? i * (i + 1) / 2 : 120 + 15 * (i - 15);
  endfunction
  function automatic int cap(input int v);
    return (v > TL) ? TL : v;
  endfunction
  function automatic int sp(input int i);
    return (i < 15) ? i : 15;
  endfunction
  function automatic bit m(input int e, input int a);
    return (e < 0) || (e == a);
  endfunction

  task automatic drive(input bit t, input bit s, input logic [1:0] k, input bit r,
                       input exp_t e);
    bus.tick  = t;
    bus.start = s;
    bus.key   = k;
    rst       = r;
    if (t || s || !r) exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic countdown(input int fs);
    for (int c = 2; c >= 0; c--)
      drive(1, 0, 2'b00, 1, mk("countdown", (c == 0) ? 2 : 1, c, 0, 0, 0, 0, fs, 0, 0, 0, 0));
  endtask

  exp_t ce;
  exp_t ca;
  bit   fire;
  initial begin
    forever begin
      @(posedge clk);
      fire = bus.tick || bus.start || !rst;
      @(negedge clk);
      if (fire) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: output event with no expectation queued, required none");
        end else begin
          ce = exp_q.pop_front();
          ca = mk(ce.name, int'(bus.state), int'(bus.count), int'(bus.pos[15:0]),
                  int'(bus.pos[31:16]), int'(bus.speed[3:0]), int'(bus.speed[7:4]),
                  int'(bus.false_start), int'(bus.finished), int'(bus.winner),
                  int'(bus.winner_vld), int'(bus.tie));
          if (m(ce.st, ca.st) && m(ce.cnt, ca.cnt) && m(ce.p0, ca.p0) && m(ce.p1, ca.p1) &&
              m(ce.s0, ca.s0) && m(ce.s1, ca.s1) && m(ce.fs, ca.fs) && m(ce.fin, ca.fin) &&
              m(ce.win, ca.win) && m(ce.wv, ca.wv) && m(ce.tie, ca.tie)) begin
            n_pass++;
          end else begin
            $display("FAIL %s: got st=%0d cnt=%0d pos=%0d,%0d spd=%0d,%0d fs=%0d fin=%0d win=%0d vld=%0d tie=%0d required st=%0d cnt=%0d pos=%0d,%0d spd=%0d,%0d fs=%0d fin=%0d win=%0d vld=%0d tie=%0d",
                     ce.name, ca.st, ca.cnt, ca.p0, ca.p1, ca.s0, ca.s1, ca.fs, ca.fin,
                     ca.win, ca.wv, ca.tie, ce.st, ce.cnt, ce.p0, ce.p1, ce.s0, ce.s1,
                     ce.fs, ce.fin, ce.win, ce.wv, ce.tie);
          end
        end
      end
    end
  end

  initial begin
    exp_t z;
    int p, s;
    z = mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.tick = 1'b0; bus.start = 1'b0; bus.key = 2'b00; rst = 1'b0;

    // Reset, ignored ticks in IDLE, start and countdown
    drive(0, 0, 2'b00, 0, z);
    drive(0, 0, 2'b00, 0, z);
    drive(1, 0, 2'b00, 1, mk("idle_tick", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 2'b00, 1, mk("idle_tick", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 1, 2'b00, 1, mk("start", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    countdown(0);

    // Race 1: acceleration to the ceiling, drag to standstill, then staggered finish
    for (int i = 1; i <= 20; i++)
      drive(1, 0, 2'b01, 1, mk("accel", 2, 0, acc_pos(i), 0, sp(i), 0, 0, 0, 0, 0, 0));
    p = 195; s = 15;
    for (int i = 0; i < 16; i++) begin
      s = (s > 0) ? s - 1 : 0;
      p = p + s;
      drive(1, 0, 2'b00, 1, mk("drag", 2, 0, p, 0, s, 0, 0, 0, 0, 0, 0));
    end
    for (int i = 1; i <= 14; i++)
      drive(1, 0, 2'b01, 1, mk("fin_lane0", 2, 0, (i < 14) ? 300 + acc_pos(i) : TL, 0,
                               (i < 14) ? i : 0, 0, 0, (i < 14) ? 0 : 1, 0,
                               (i < 14) ? 0 : 1, 0));
    for (int i = 1; i <= 34; i++)
      drive(1, 0, 2'b11, 1, mk("fin_lane1", (i < 34) ? 2 : 3, 0, TL, cap(acc_pos(i)), 0,
                               (i < 34) ? sp(i) : 0, 0, (i < 34) ? 1 : 3, 0, 1, 0));

    // Race 2: identical inputs, dead heat on the clamped finish tick
    drive(0, 1, 2'b00, 1, mk("restart", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    countdown(0);
    for (int i = 1; i <= 34; i++)
      drive(1, 0, 2'b11, 1, mk("tie", (i < 34) ? 2 : 3, 0, cap(acc_pos(i)), cap(acc_pos(i)),
                               (i < 34) ? sp(i) : 0, (i < 34) ? sp(i) : 0, 0,
                               (i < 34) ? 0 : 3, 0, (i < 34) ? 0 : 1, (i < 34) ? 0 : 1));

    // Race 3: lane 1 one tick ahead
    drive(0, 1, 2'b00, 1, mk("restart", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    countdown(0);
    drive(1, 0, 2'b10, 1, mk("lead1", 2, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 34; i++)
      drive(1, 0, 2'b11, 1, mk("lead1", (i < 34) ? 2 : 3, 0, cap(acc_pos(i)), cap(acc_pos(i + 1)),
                               (i < 34) ? sp(i) : 0, (i < 33) ? sp(i + 1) : 0, 0,
                               ((i >= 33) ? 2 : 0) | ((i >= 34) ? 1 : 0),
                               (i >= 33) ? 1 : 0, (i >= 33) ? 1 : 0, 0));

    // Race 4: lane 1 false start from a single-cycle key pulse
    drive(0, 1, 2'b00, 1, mk("restart", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 2'b10, 1, z);
    countdown(2);
    for (int i = 1; i <= 34; i++)
      drive(1, 0, 2'b11, 1, mk("false_start", (i < 34) ? 2 : 3, 0, cap(acc_pos(i)), 0,
                               (i < 34) ? sp(i) : 0, 0, 2, (i < 34) ? 0 : 1, 0,
                               (i < 34) ? 0 : 1, 0));

    // Race 5: every lane disqualified ends the race with no winner
    drive(0, 1, 2'b00, 1, mk("restart", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 2'b11, 1, z);
    countdown(3);
    drive(0, 0, 2'b00, 1, z);
    drive(1, 0, 2'b00, 1, mk("all_dq", 3, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0));

    // Race 6: reset during a race tick, then a tick in IDLE
    drive(0, 1, 2'b00, 1, mk("restart", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    countdown(0);
    drive(1, 0, 2'b01, 1, mk("pre_reset", 2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 2'b01, 1, mk("pre_reset", 2, 0, 3, 0, 2, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 2'b01, 0, mk("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 2'b00, 1, mk("post_reset_tick", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 2'b00, 1, z);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
